bcd_to_binary: RTL and testbench

Sequential BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3 from any nibble >= 8).
- Inverse of the binary-to-BCD engine; same start/data-valid handshake style.
- Converts operator-entered or display-domain BCD counts (e.g. from the 4-digit 7-segment path) back to binary for arithmetic and comparison.
- Flags non-decimal digits instead of converting them.

---
 rtl/bcd_to_binary.sv | 138 +++++++++++++
 tb/tb_bcd_to_binary.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble: one right shift per clock,
// then subtract 3 from every BCD nibble that lands at 8 or above.
module bcd_to_binary #(
    parameter int unsigned OUTPUT_WIDTH   = 16,
    parameter int unsigned DECIMAL_DIGITS = 4
) (
    input  logic                        i_clk,
    input  logic                        i_resetn,
    input  logic [4*DECIMAL_DIGITS-1:0] i_bcd,
    input  logic                        i_start,
    output logic [OUTPUT_WIDTH-1:0]     o_binary,
    output logic                        o_dv,
    output logic                        o_error,
    output logic                        o_busy
);

    localparam int unsigned BcdW = 4 * DECIMAL_DIGITS;
    localparam int unsigned ScrW = BcdW + OUTPUT_WIDTH;
    localparam int unsigned CntW = $clog2(OUTPUT_WIDTH + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(OUTPUT_WIDTH - 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned DecRange = pow10(DECIMAL_DIGITS);
    localparam longint unsigned BinRange = 64'd1 << OUTPUT_WIDTH;

    // Too narrow a result would leave residue in the BCD part after the last iteration.
    if (DecRange > BinRange) begin : g_bad_width
        $error("bcd_to_binary: OUTPUT_WIDTH too small for DECIMAL_DIGITS");
    end

    typedef enum logic [0:0] {
        StIdle,
        StConvert
    } state_e;

    state_e                  state_q, state_d;
    logic [ScrW-1:0]         scratch_q, scratch_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [OUTPUT_WIDTH-1:0] binary_q, binary_d;
    logic                    dv_q, dv_d;
    logic                    error_q, error_d;
    logic                    busy_q, busy_d;

    logic [ScrW-1:0]         shifted;
    logic [ScrW-1:0]         iter;
    logic                    bcd_invalid;

    always_comb begin
        shifted = scratch_q >> 1;
        iter    = shifted;
        for (int i = 0; i < int'(DECIMAL_DIGITS); i++) begin
            if (shifted[OUTPUT_WIDTH+4*i +: 4] >= 4'd8) begin
                iter[OUTPUT_WIDTH+4*i +: 4] = shifted[OUTPUT_WIDTH+4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bcd_invalid = 1'b0;
        for (int i = 0; i < int'(DECIMAL_DIGITS); i++) begin
            if (i_bcd[4*i +: 4] > 4'd9) begin
                bcd_invalid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        binary_d  = binary_q;
        dv_d      = 1'b0;
        error_d   = error_q;
        busy_d    = busy_q;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (bcd_invalid) begin
                        binary_d = '0;
                        error_d  = 1'b1;
                        dv_d     = 1'b1;
                    end else begin
                        scratch_d = {i_bcd, {OUTPUT_WIDTH{1'b0}}};
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        state_d   = StConvert;
                    end
                end
            end
            StConvert: begin
                scratch_d = iter;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    binary_d = iter[OUTPUT_WIDTH-1:0];
                    error_d  = 1'b0;
                    dv_d     = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q   <= StIdle;
            scratch_q <= '0;
            cnt_q     <= '0;
            binary_q  <= '0;
            dv_q      <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            binary_q  <= binary_d;
            dv_q      <= dv_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
        end
    end

    assign o_binary = binary_q;
    assign o_dv     = dv_q;
    assign o_error  = error_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: default 4-digit/16-bit instance plus a 2-digit/7-bit instance,
// checked against a decimal-weighting reference model.
module tb_bcd_to_binary;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_a, start_a, dv_a, err_a, busy_a;
    logic [15:0] bcd_a, bin_a;
    logic        rstn_b, start_b, dv_b, err_b, busy_b;
    logic [7:0]  bcd_b;
    logic [6:0]  bin_b;

    int tests = 0;
    int fails = 0;

    bcd_to_binary #(.OUTPUT_WIDTH(16), .DECIMAL_DIGITS(4)) u_dut_a (
        .i_clk(clk), .i_resetn(rstn_a), .i_bcd(bcd_a), .i_start(start_a),
        .o_binary(bin_a), .o_dv(dv_a), .o_error(err_a), .o_busy(busy_a)
    );

    bcd_to_binary #(.OUTPUT_WIDTH(7), .DECIMAL_DIGITS(2)) u_dut_b (
        .i_clk(clk), .i_resetn(rstn_b), .i_bcd(bcd_b), .i_start(start_b),
        .o_binary(bin_b), .o_dv(dv_b), .o_error(err_b), .o_busy(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_val(input logic [15:0] bcd, input int nd);
        int unsigned v = 0;
        int unsigned p = 1;
        for (int i = 0; i < nd; i++) begin
            v = v + int'(bcd[4*i +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic bit model_err(input logic [15:0] bcd, input int nd);
        bit e = 1'b0;
        for (int i = 0; i < nd; i++) begin
            if (bcd[4*i +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    // Returns at #1 after the o_dv edge so a following call starts inside the o_dv cycle.
    task automatic run_a(input logic [15:0] bcd, input bit disturb);
        int lat;
        int busy_n;
        bit exp_err;
        int unsigned exp_v;
        exp_err = model_err(bcd, 4);
        exp_v   = exp_err ? 0 : model_val(bcd, 4);
        @(negedge clk);
        bcd_a   = bcd;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        lat     = 0;
        busy_n  = 0;
        while (!dv_a && lat < 40) begin
            if (busy_a) busy_n++;
            if (disturb) begin
                bcd_a   = 16'h1111;
                start_a = lat[0];
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start_a = 1'b0;
        check("a_latency", lat, exp_err ? 0 : 16);
        check("a_busy_cycles", busy_n, exp_err ? 0 : 16);
        check("a_binary", bin_a, exp_v);
        check("a_error", err_a, exp_err);
        check("a_busy_at_dv", busy_a, 0);
    endtask

    task automatic run_b(input logic [7:0] bcd);
        int lat;
        int busy_n;
        bit exp_err;
        int unsigned exp_v;
        exp_err = model_err({8'h00, bcd}, 2);
        exp_v   = exp_err ? 0 : model_val({8'h00, bcd}, 2);
        @(negedge clk);
        bcd_b   = bcd;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        lat     = 0;
        busy_n  = 0;
        while (!dv_b && lat < 40) begin
            if (busy_b) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("b_latency", lat, exp_err ? 0 : 7);
        check("b_busy_cycles", busy_n, exp_err ? 0 : 7);
        check("b_binary", bin_b, exp_v);
        check("b_error", err_b, exp_err);
    endtask

    task automatic quiet_a(input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (dv_a) seen++;
        end
        check("a_extra_dv", seen, 0);
    endtask

    initial begin
        logic [15:0] v;
        int seen;
        rstn_a = 1'b0; start_a = 1'b0; bcd_a = '0;
        rstn_b = 1'b0; start_b = 1'b0; bcd_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_binary", bin_a, 0);
        check("rst_dv", dv_a, 0);
        check("rst_error", err_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_b_binary", bin_b, 0);
        check("rst_b_busy", busy_b, 0);
        @(negedge clk);
        rstn_a = 1'b1;
        rstn_b = 1'b1;

        run_a(16'h1234, 1'b0);
        quiet_a(3);
        run_a(16'h9999, 1'b0);
        run_a(16'h0000, 1'b0);
        run_a(16'h12A4, 1'b0);
        run_a(16'h0042, 1'b0);
        run_a(16'h5678, 1'b1);
        quiet_a(20);

        // Reset mid-conversion: outputs clear asynchronously and no o_dv follows.
        @(negedge clk);
        bcd_a   = 16'h0999;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rstn_a = 1'b0;
        #1;
        check("arst_binary", bin_a, 0);
        check("arst_dv", dv_a, 0);
        check("arst_error", err_a, 0);
        check("arst_busy", busy_a, 0);
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (dv_a) seen++;
        end
        @(negedge clk);
        rstn_a = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (dv_a) seen++;
        end
        check("arst_no_dv", seen, 0);
        run_a(16'h0007, 1'b0);

        repeat (40) begin
            for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            run_a(v, 1'b0);
        end

        for (int k = 0; k < 256; k++) begin
            run_b(8'(k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
